// File: rtl/rf_mp_scoreboard.sv
// Parametrised multi-read, dual-write register file with optional write-to-read
// bypass, optional hardwired-zero register 0 and a per-register pending-write scoreboard.

module rf_mp_rd_lane #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_pend,
  input  logic              wr0_act,
  input  logic [ADDR_W-1:0] wr0_reg,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_act,
  input  logic [ADDR_W-1:0] wr1_reg,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);
  logic is_zero, hit0, hit1;

  always_comb begin
    is_zero = (ZERO_REG != 0) && (raddr == '0);
    hit1    = (BYPASS != 0) && wr1_act && (wr1_reg == raddr);
    hit0    = (BYPASS != 0) && wr0_act && (wr0_reg == raddr);
    rdata   = st_data;
    rbusy   = st_pend;
    // port 1 (DM) is the younger result, so it wins the forward
    if (is_zero) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if (hit1) begin
      rdata = wr1_data;
      rbusy = 1'b0;
    end else if (hit0) begin
      rdata = wr0_data;
      rbusy = 1'b0;
    end
  end
endmodule

module rf_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_reg,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_reg,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_reg,
  output logic [ADDR_W:0]          pending_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [DEPTH-1:0]              pend_q, pend_d;
  logic [ADDR_W:0]               pending_cnt_q, pending_cnt_d;
  logic                          wr0_act, wr1_act, mark_act;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data, st_data;
  logic [NUM_RD-1:0]             st_pend;

  // gating with rst_n keeps forwarded data at zero while held in reset
  assign wr0_act  = rst_n && wr0_en  && !((ZERO_REG != 0) && (wr0_reg  == '0));
  assign wr1_act  = rst_n && wr1_en  && !((ZERO_REG != 0) && (wr1_reg  == '0));
  assign mark_act = rst_n && mark_en && !((ZERO_REG != 0) && (mark_reg == '0));

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr0_act) begin
      regs_d[wr0_reg] = wr0_data;
      pend_d[wr0_reg] = 1'b0;
    end
    if (wr1_act) begin
      regs_d[wr1_reg] = wr1_data;
      pend_d[wr1_reg] = 1'b0;
    end
    // a newly issued producer outranks the retiring write
    if (mark_act) pend_d[mark_reg] = 1'b1;
    pending_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      pending_cnt_d = pending_cnt_d + (ADDR_W+1)'(pend_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q        <= '0;
      pend_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      pend_q        <= pend_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign rd_addr     = read_reg;
  assign read_data   = rd_data;
  assign pending_cnt = pending_cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign st_data[k] = regs_q[rd_addr[k]];
    assign st_pend[k] = pend_q[rd_addr[k]];

    rf_mp_rd_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_lane (
      .raddr   (rd_addr[k]),
      .st_data (st_data[k]),
      .st_pend (st_pend[k]),
      .wr0_act (wr0_act),
      .wr0_reg (wr0_reg),
      .wr0_data(wr0_data),
      .wr1_act (wr1_act),
      .wr1_reg (wr1_reg),
      .wr1_data(wr1_data),
      .rdata   (rd_data[k]),
      .rbusy   (read_busy[k])
    );
  end
endmodule
